// File: rtl/shift_req_arbiter_if.sv
// Purpose: bundles the two requester ports, the external shifter hookup and the result port.
// Latency: none, signal bundle only.
// Backpressure: carried by reqX_ready / res_ready inside the bundle.
// Ports (signals):
//   req0_*/req1_*  valid/ready + operand a (signed) and shift amount b (unsigned) per requester
//   sh_a/sh_b/sh_y  operands out to, and result back from, the external arithmetic-right shifter
//   res_*           registered result with valid/ready and requester ID tag
//   done0/1_cnt     wrapping per-requester count of results handed to the consumer
// Modports: slave = arbiter view, master = surrounding logic (requesters, shifter, consumer).
interface shift_req_arbiter_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [N-1:0]     req0_a;
  logic [N-1:0]     req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [N-1:0]     req1_a;
  logic [N-1:0]     req1_b;
  logic [N-1:0]     sh_a;
  logic [N-1:0]     sh_b;
  logic [N-1:0]     sh_y;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_out;
  logic             res_id;
  logic [CNT_W-1:0] done0_cnt;
  logic [CNT_W-1:0] done1_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  sh_y, res_ready,
    output req0_ready, req1_ready,
    output sh_a, sh_b,
    output res_valid, res_out, res_id,
    output done0_cnt, done1_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output sh_y, res_ready,
    input  req0_ready, req1_ready,
    input  sh_a, sh_b,
    input  res_valid, res_out, res_id,
    input  done0_cnt, done1_cnt
  );
endinterface

// File: rtl/shift_req_arbiter.sv
// Purpose: round-robin share of one external N-bit arithmetic-right shifter between two requesters.
// Latency: 1 cycle from accept (valid&ready) to res_valid; sustains one op per cycle.
// Backpressure: res_valid & !res_ready stalls both requesters; result, ID and arbitration state hold.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any pending result
//   bus    shift_req_arbiter_if.slave (requesters, shifter hookup, result, completion counters)
module shift_req_arbiter #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_req_arbiter_if.slave  bus
);

  logic             res_valid_q;
  logic [N-1:0]     res_out_q;
  logic             res_id_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] done0_q;
  logic [CNT_W-1:0] done1_q;

  logic can_accept;
  logic gnt_vld;
  logic gnt_id;
  logic accept;
  logic drain;

  // Grant only looks at the valids, never at the operands, so ready has no
  // combinational path from a requester's own a/b.
  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    gnt_id  = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_grant_q;
    end
  end

  // The output register can take a new result if empty or being emptied now.
  assign can_accept = ~res_valid_q | bus.res_ready;
  assign accept     = can_accept & gnt_vld;
  assign drain      = res_valid_q & bus.res_ready;

  assign bus.req0_ready = accept & ~gnt_id;
  assign bus.req1_ready = accept & gnt_id;

  // gnt_id is 0 when nobody is valid, so the idle shifter sees req0's operands.
  assign bus.sh_a = gnt_id ? bus.req1_a : bus.req0_a;
  assign bus.sh_b = gnt_id ? bus.req1_b : bus.req0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_out_q    <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;  // makes requester 0 win the first tie
    end else begin
      if (accept) begin
        res_valid_q  <= 1'b1;
        res_out_q    <= bus.sh_y;
        res_id_q     <= gnt_id;
        last_grant_q <= gnt_id;
      end else if (drain) begin
        res_valid_q  <= 1'b0;
      end
    end
  end

  // Completion counters credit the requester whose result is leaving,
  // i.e. the ID currently in the register, not the one being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_q <= '0;
      done1_q <= '0;
    end else if (drain) begin
      if (res_id_q) begin
        done1_q <= done1_q + CNT_W'(1);
      end else begin
        done0_q <= done0_q + CNT_W'(1);
      end
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_out   = res_out_q;
  assign bus.res_id    = res_id_q;
  assign bus.done0_cnt = done0_q;
  assign bus.done1_cnt = done1_q;

endmodule
